// File: rtl/ftdi_tx_packer_if.sv
// ftdi_tx_packer_if: the core-side word handshake and the FTDI FT245 transmit pins.
//  master (packer side): drives usb_dout/usb_oe/usb_wr/usb_siwua, tx_ce and busy;
//                        samples usb_txe, tx and tx_en.
//  slave  (core + pad side): the mirror image.
interface ftdi_tx_packer_if;
  logic [7:0]  usb_dout;
  logic        usb_oe;
  logic        usb_txe;
  logic        usb_wr;
  logic        usb_siwua;
  logic [31:0] tx;
  logic        tx_en;
  logic        tx_ce;
  logic        busy;

  modport master (
    output usb_dout, usb_oe, usb_wr, usb_siwua, tx_ce, busy,
    input  usb_txe, tx, tx_en
  );

  modport slave (
    input  usb_dout, usb_oe, usb_wr, usb_siwua, tx_ce, busy,
    output usb_txe, tx, tx_en
  );
endinterface

// File: rtl/ftdi_tx_packer.sv
// ftdi_tx_packer: transmit half of an FT245-style USB FIFO link.
//  Takes 32-bit words from the core (tx/tx_en/tx_ce), buffers one in a holding
//  register, and writes each as four bytes MSB first using the TXE#/WR handshake.
//  Pulses SI/WU# after the link has been idle for SIWU_IDLE clocks since the last
//  latched byte, so the FTDI flushes a partial USB packet.
// Ports:
//  clock, reset_n : system clock, synchronous active-low reset
//  bus (master)   : usb_dout/usb_oe/usb_wr/usb_siwua out, usb_txe in,
//                   tx/tx_en in, tx_ce/busy out
// Timing counters are 8 bits wide; WR_SETUP/WR_PULSE/WR_HOLD must be 1..256.
module ftdi_tx_packer #(
  parameter int WR_SETUP  = 2,
  parameter int WR_PULSE  = 5,
  parameter int WR_HOLD   = 2,
  parameter int SIWU_IDLE = 64
) (
  input logic               clock,
  input logic               reset_n,
  ftdi_tx_packer_if.master  bus
);
  localparam int CW = 8;
  localparam logic [CW-1:0] SETUP_LAST = CW'(WR_SETUP - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(WR_PULSE - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(WR_HOLD - 1);
  localparam int IW = (SIWU_IDLE > 1) ? $clog2(SIWU_IDLE) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'((SIWU_IDLE > 0) ? SIWU_IDLE - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_SETUP, S_PULSE, S_HOLD, S_GAP, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [31:0]     shift_q, shift_d;
  logic [31:0]     hold_q, hold_d;
  logic            hold_v_q, hold_v_d;
  logic            txe_q, txe_d;
  logic [7:0]      dout_q, dout_d;
  logic            oe_q, oe_d;
  logic            wr_q, wr_d;
  logic            siwua_q, siwua_d;
  logic [CW-1:0]   siwu_cnt_q, siwu_cnt_d;
  logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
  logic            bsf_q, bsf_d;  // bytes written since last SI/WU# flush
  logic            unload;
  logic            tx_ce;
  logic [7:0]      byte_sel;

  always_comb begin
    case (idx_q)
      2'd0:    byte_sel = shift_q[31:24];
      2'd1:    byte_sel = shift_q[23:16];
      2'd2:    byte_sel = shift_q[15:8];
      default: byte_sel = shift_q[7:0];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    hold_v_d   = hold_v_q;
    txe_d      = bus.usb_txe;
    dout_d     = dout_q;
    oe_d       = oe_q;
    wr_d       = wr_q;
    siwua_d    = siwua_q;
    siwu_cnt_d = siwu_cnt_q;
    idle_cnt_d = idle_cnt_q;
    bsf_d      = bsf_q;
    unload     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // a word arriving during an SI/WU# pulse is held until the pulse ends
        if (hold_v_q && siwua_q) begin
          unload  = 1'b1;
          shift_d = hold_q;
          idx_d   = 2'd0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!txe_q) begin
          oe_d    = 1'b1;
          dout_d  = byte_sel;
          cnt_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          wr_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_PULSE;
        end else cnt_d = cnt_q + 8'd1;
      end
      S_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          wr_d       = 1'b0;
          cnt_d      = '0;
          idle_cnt_d = '0;
          bsf_d      = 1'b1;
          state_d    = S_HOLD;
        end else cnt_d = cnt_q + 8'd1;
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          oe_d  = 1'b0;
          cnt_d = '0;
          if (idx_q == 2'd3) state_d = S_DONE;
          else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_GAP;
          end
        end else cnt_d = cnt_q + 8'd1;
      end
      S_GAP: begin
        // give TXE# time to deassert after the strobe before trusting it again
        if (txe_q || cnt_q == 8'd1) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else cnt_d = cnt_q + 8'd1;
      end
      S_DONE: begin
        if (hold_v_q) begin
          unload  = 1'b1;
          shift_d = hold_q;
          idx_d   = 2'd0;
          state_d = S_WAIT;
        end else state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Idle time is measured from the last strobe fall; it advances only while
    // no new byte is being offered, and the pulse itself fires only from IDLE.
    if (SIWU_IDLE != 0 && bsf_q && siwua_q &&
        (state_q == S_HOLD || state_q == S_DONE || state_q == S_IDLE)) begin
      if (idle_cnt_q == IDLE_LAST) begin
        if (state_q == S_IDLE && !hold_v_q) begin
          siwua_d    = 1'b0;
          siwu_cnt_d = '0;
          bsf_d      = 1'b0;
          idle_cnt_d = '0;
        end
      end else idle_cnt_d = idle_cnt_q + 1'b1;
    end

    if (!siwua_q) begin
      if (siwu_cnt_q == PULSE_LAST) siwua_d = 1'b1;
      else siwu_cnt_d = siwu_cnt_q + 8'd1;
    end

    // hold may be refilled on the same clock it is emptied into the shifter
    tx_ce = reset_n & bus.tx_en & (~hold_v_q | unload);
    if (unload) hold_v_d = 1'b0;
    if (tx_ce) begin
      hold_d   = bus.tx;
      hold_v_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      hold_q     <= '0;
      hold_v_q   <= 1'b0;
      txe_q      <= 1'b1;
      dout_q     <= '0;
      oe_q       <= 1'b0;
      wr_q       <= 1'b0;
      siwua_q    <= 1'b1;
      siwu_cnt_q <= '0;
      idle_cnt_q <= '0;
      bsf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      hold_v_q   <= hold_v_d;
      txe_q      <= txe_d;
      dout_q     <= dout_d;
      oe_q       <= oe_d;
      wr_q       <= wr_d;
      siwua_q    <= siwua_d;
      siwu_cnt_q <= siwu_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      bsf_q      <= bsf_d;
    end
  end

  assign bus.usb_dout  = dout_q;
  assign bus.usb_oe    = oe_q;
  assign bus.usb_wr    = wr_q;
  assign bus.usb_siwua = siwua_q;
  assign bus.tx_ce     = tx_ce;
  assign bus.busy      = hold_v_q | (state_q != S_IDLE);
endmodule

// File: tb/tb_ftdi_tx_packer.sv
// Directed bench for ftdi_tx_packer: watches the FTDI pins like the chip would,
// collects bytes on each usb_wr fall, and checks framing, order, backpressure,
// SI/WU# timing and reset recovery.
module tb_ftdi_tx_packer;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  ftdi_tx_packer_if bus();

  ftdi_tx_packer #(.WR_SETUP(2), .WR_PULSE(5), .WR_HOLD(2), .SIWU_IDLE(64)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] q[$];
  int fall_cyc[$];
  int last_fall = 0;
  int siwu_pulses = 0, siwu_delay = -1, siwu_width = -1, siwu_lo = 0;
  int ce_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // pin monitor, sampled mid-cycle
  initial begin : mon
    logic p_oe, p_siwua;
    logic [7:0] oe_dout;
    int phase, setup_n, wr_n, hold_n;
    p_oe = 0; p_siwua = 1; oe_dout = 0; phase = 0; setup_n = 0; wr_n = 0; hold_n = 0;
    forever begin
      @(negedge clock);
      if (bus.tx_ce === 1'b1) ce_cnt++;
      if (reset_n) begin
        if (bus.usb_oe && !p_oe) begin
          oe_dout = bus.usb_dout; phase = 0; setup_n = 0; wr_n = 0; hold_n = 0;
        end
        if (bus.usb_wr) chk("wr_needs_oe", bus.usb_oe, 1);
        if (bus.usb_oe) begin
          chk("dout_stable", bus.usb_dout, oe_dout);
          if (bus.usb_wr) begin
            if (phase == 0) begin chk("setup_len", setup_n, 2); phase = 1; end
            wr_n++;
          end else if (phase == 0) setup_n++;
          else begin
            if (phase == 1) begin
              chk("wr_width", wr_n, 5);
              phase = 2;
              q.push_back(bus.usb_dout);
              fall_cyc.push_back(cyc);
              last_fall = cyc;
            end
            hold_n++;
          end
        end
        if (!bus.usb_oe && p_oe) chk("hold_len", hold_n, 2);
        if (!bus.usb_siwua && p_siwua) begin
          siwu_pulses++; siwu_delay = cyc - last_fall; siwu_lo = 0;
        end
        if (!bus.usb_siwua) siwu_lo++;
        if (bus.usb_siwua && !p_siwua) siwu_width = siwu_lo;
      end
      p_oe = bus.usb_oe;
      p_siwua = bus.usb_siwua;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic send_word(input logic [31:0] w, input int budget);
    int n = 0;
    bit got = 0;
    @(posedge clock); #1;
    bus.tx = w; bus.tx_en = 1'b1;
    while (!got && n < budget) begin
      @(negedge clock);
      if (bus.tx_ce === 1'b1) got = 1;
      else begin @(posedge clock); #1; n++; end
    end
    chk($sformatf("tx_accept_%h", w), got, 1);
    @(posedge clock); #1;
    bus.tx_en = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int k = 0;
    while (q.size() < n && k < budget) begin @(negedge clock); k++; end
    chk("byte_count", q.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    @(negedge clock);
    while (bus.busy !== 1'b0 && k < budget) begin @(negedge clock); k++; end
    chk("went_idle", bus.busy, 0);
  endtask

  task automatic chk_bytes(input string tag, input logic [95:0] exp, input int n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_b%0d", tag, i), (i < q.size()) ? q[i] : 8'hxx,
          exp[95 - 8*i -: 8]);
  endtask

  initial begin
    int ce0, wr_hits, qs, k;
    bit got;
    bus.usb_txe = 1'b0; bus.tx = '0; bus.tx_en = 1'b0;

    // 1: reset
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_wr", bus.usb_wr, 0);
    chk("rst_oe", bus.usb_oe, 0);
    chk("rst_siwua", bus.usb_siwua, 1);
    chk("rst_tx_ce", bus.tx_ce, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_dout", bus.usb_dout, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // 2: single word
    q.delete(); fall_cyc.delete();
    ce0 = ce_cnt;
    send_word(32'hABADBABE, 20);
    wait_bytes(4, 200);
    chk_bytes("t2", {32'hABADBABE, 64'h0}, 4);
    wait_idle(50);
    chk("t2_ce_pulses", ce_cnt - ce0, 1);

    // 5: SI/WU# flush after idle
    repeat (150) @(negedge clock);
    chk("t5_siwu_pulses", siwu_pulses, 1);
    chk("t5_siwu_delay", siwu_delay, 64);
    chk("t5_siwu_width", siwu_width, 5);
    repeat (100) @(negedge clock);
    chk("t5_no_repeat", siwu_pulses, 1);

    // 3: back-to-back words
    q.delete(); fall_cyc.delete();
    send_word(32'hFEEDF00D, 20);
    send_word(32'h0BADF00D, 200);
    wait_bytes(8, 400);
    chk_bytes("t3", {64'hFEEDF00D_0BADF00D, 32'h0}, 8);
    for (int i = 1; i < 8; i++)
      chk($sformatf("t3_spacing%0d", i),
          (i < fall_cyc.size()) ? ((fall_cyc[i] - fall_cyc[i-1]) <= 12) : 1'b0, 1);
    wait_idle(50);

    // 4: backpressure: shifter and hold fill, third word stalls
    @(posedge clock); #1;
    bus.usb_txe = 1'b1;
    q.delete(); fall_cyc.delete();
    send_word(32'h11223344, 20);
    send_word(32'h55667788, 20);
    @(posedge clock); #1;
    bus.tx = 32'h99AABBCC; bus.tx_en = 1'b1;
    ce0 = ce_cnt; wr_hits = 0;
    repeat (200) begin @(negedge clock); if (bus.usb_wr) wr_hits++; end
    chk("t4_no_ce", ce_cnt - ce0, 0);
    chk("t4_no_wr", wr_hits, 0);
    chk("t4_busy", bus.busy, 1);
    @(posedge clock); #1;
    bus.usb_txe = 1'b0;
    got = 0; k = 0; qs = -1;
    while (!got && k < 400) begin
      @(negedge clock);
      if (bus.tx_ce === 1'b1) begin got = 1; qs = q.size(); end
      else k++;
    end
    chk("t4_w3_accept", got, 1);
    chk("t4_w3_after_word1", qs, 4);
    @(posedge clock); #1;
    bus.tx_en = 1'b0;
    wait_bytes(12, 800);
    chk_bytes("t4", 96'h11223344_55667788_99AABBCC, 12);
    wait_idle(50);

    // 6: reset in the middle of byte 2's strobe
    q.delete(); fall_cyc.delete();
    send_word(32'hCAFED00D, 20);
    k = 0;
    while (!(q.size() == 1 && bus.usb_wr === 1'b1) && k < 300) begin
      @(negedge clock); k++;
    end
    chk("t6_in_byte2", bus.usb_wr, 1);
    reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("t6_wr_drop", bus.usb_wr, 0);
    chk("t6_oe_drop", bus.usb_oe, 0);
    chk("t6_busy_clr", bus.busy, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    q.delete(); fall_cyc.delete();
    send_word(32'h12345678, 20);
    wait_bytes(4, 200);
    chk_bytes("t6", {32'h12345678, 64'h0}, 4);
    wait_idle(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
